// File: rtl/rr_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_dispatch_pkg
// Brief    : Shared constants and state encoding for the round-robin dispatcher.
// Revision : 1.0  initial release
// ============================================================================
package rr_dispatch_pkg;

    localparam int CH_NUM   = 4;
    localparam int SEL_BITS = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_dispatch_if
// Brief    : Upstream handshake plus downstream demux control bundle.
// Revision : 1.0  initial release
// ============================================================================
interface rr_dispatch_if
    import rr_dispatch_pkg::*;
#(
    parameter int BITS_NUM = 2,
    parameter int CNT_BITS = 8
) ();

    logic [BITS_NUM-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [CH_NUM-1:0]   ch_ready;
    logic [BITS_NUM-1:0] x;
    logic [SEL_BITS-1:0] sel;
    logic [CH_NUM-1:0]   ch_valid;
    logic [CNT_BITS-1:0] disp_cnt;

    // master: upstream producer and downstream consumers
    modport master (
        output in_data, in_valid, ch_ready,
        input  in_ready, x, sel, ch_valid, disp_cnt
    );

    // slave: the dispatcher itself
    modport slave (
        input  in_data, in_valid, ch_ready,
        output in_ready, x, sel, ch_valid, disp_cnt
    );

endinterface
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_4
// Brief    : Combinational circular first-ready search over four channels.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick_4
    import rr_dispatch_pkg::*;
(
    input  wire logic [SEL_BITS-1:0] start,
    input  wire logic [CH_NUM-1:0]   req,
    output logic      [SEL_BITS-1:0] gnt,
    output logic                     any
);

    logic [SEL_BITS-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        gnt   = start;
        any   = 1'b0;
        w_idx = start;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            w_idx = start + SEL_BITS'(i);
            if (req[w_idx]) begin
                gnt = w_idx;
                any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_dispatch_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_dispatch_4
// Brief    : One-word holding stage dispatching round-robin into a 1-to-4 demux.
//            Optional ready-skipping enabled by macro RR_DISPATCH_SKIP_EN.
// Revision : 1.0  initial release
// ============================================================================
module rr_dispatch_4
    import rr_dispatch_pkg::*;
#(
    parameter int BITS_NUM = 2,
    parameter int CNT_BITS = 8
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    rr_dispatch_if.slave bus
);

    state_t              r_state;
    logic [SEL_BITS-1:0] r_ptr;
    logic [SEL_BITS-1:0] r_sel;
    logic [BITS_NUM-1:0] r_x;
    logic [CNT_BITS-1:0] r_cnt;

    state_t              w_state_nxt;
    logic [SEL_BITS-1:0] w_ptr_nxt;
    logic [SEL_BITS-1:0] w_sel_nxt;
    logic [BITS_NUM-1:0] w_x_nxt;
    logic [CNT_BITS-1:0] w_cnt_nxt;

    logic                w_xfer;
    logic                w_accept;
    logic [SEL_BITS-1:0] w_sel_inc;
    logic [SEL_BITS-1:0] w_ptr_post;
    logic [SEL_BITS-1:0] w_target;

    assign w_xfer     = (r_state == HOLD) && bus.ch_ready[r_sel];
    assign w_sel_inc  = r_sel + SEL_BITS'(1);
    // The accept target is computed from the pointer as it will be after this edge's transfer.
    assign w_ptr_post = w_xfer ? w_sel_inc : r_ptr;

`ifdef RR_DISPATCH_SKIP_EN
    logic [SEL_BITS-1:0] w_acc_gnt;
    logic                w_acc_any;
    logic [SEL_BITS-1:0] w_skip_gnt;
    logic                w_skip_any;

    rr_pick_4 u_pick_acc (
        .start (w_ptr_post),
        .req   (bus.ch_ready),
        .gnt   (w_acc_gnt),
        .any   (w_acc_any)
    );

    rr_pick_4 u_pick_skip (
        .start (w_sel_inc),
        .req   (bus.ch_ready),
        .gnt   (w_skip_gnt),
        .any   (w_skip_any)
    );

    assign w_target = w_acc_any ? w_acc_gnt : w_ptr_post;
`else
    assign w_target = w_ptr_post;
`endif

    always_comb begin
        bus.in_ready = (r_state == IDLE) || w_xfer;
        bus.ch_valid = (r_state == HOLD) ? (CH_NUM'(1) << r_sel) : '0;
        w_accept     = bus.in_valid && bus.in_ready;

        w_state_nxt  = r_state;
        w_ptr_nxt    = w_ptr_post;
        w_sel_nxt    = r_sel;
        w_x_nxt      = r_x;
        w_cnt_nxt    = w_xfer ? (r_cnt + CNT_BITS'(1)) : r_cnt;

        if (w_accept) begin
            w_state_nxt = HOLD;
            w_x_nxt     = bus.in_data;
            w_sel_nxt   = w_target;
        end else if (w_xfer) begin
            w_state_nxt = IDLE;
        end
`ifdef RR_DISPATCH_SKIP_EN
        else if ((r_state == HOLD) && w_skip_any) begin
            w_sel_nxt = w_skip_gnt;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_x     <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_x     <= w_x_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bus.x        = r_x;
    assign bus.sel      = r_sel;
    assign bus.disp_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rr_dispatch_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_dispatch_4
// Brief    : Randomized and directed check of rr_dispatch_4 against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rr_dispatch_4;

`ifdef RR_DISPATCH_SKIP_EN
    localparam bit c_SKIP = 1'b1;
`else
    localparam bit c_SKIP = 1'b0;
`endif

    logic clk;
    logic rst_n;

    rr_dispatch_if #(.BITS_NUM(2), .CNT_BITS(8)) bus8 ();
    rr_dispatch_if #(.BITS_NUM(2), .CNT_BITS(2)) bus2 ();

    assign bus2.in_data  = bus8.in_data;
    assign bus2.in_valid = bus8.in_valid;
    assign bus2.ch_ready = bus8.ch_ready;

    rr_dispatch_4 #(.BITS_NUM(2), .CNT_BITS(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    rr_dispatch_4 #(.BITS_NUM(2), .CNT_BITS(2)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a held word, its channel, a rotation pointer and a transfer tally.
    bit m_held;
    int m_x;
    int m_sel;
    int m_ptr;
    int m_transfers;

    function automatic int first_ready(input int from, input logic [3:0] rdy);
        for (int k = 0; k < 4; k++) begin
            if (rdy[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    task automatic cycle(input logic rn, input logic v, input logic [1:0] d, input logic [3:0] rdy);
        bit          xfer;
        bit          acc;
        int          pick;
        logic [1:0]  y [4];
        @(negedge clk);
        rst_n         = rn;
        bus8.in_valid = v;
        bus8.in_data  = d;
        bus8.ch_ready = rdy;
        #1;
        xfer = m_held && rdy[m_sel];
        acc  = v && (!m_held || xfer);
        check_val("in_ready", {31'd0, bus8.in_ready}, {31'd0, (!m_held || xfer)});
        check_val("ch_valid", {28'd0, bus8.ch_valid}, m_held ? (32'd1 << m_sel) : 32'd0);
        check_val("sel",      {30'd0, bus8.sel},      m_sel);
        check_val("x",        {30'd0, bus8.x},        m_x);
        check_val("cnt8",     {24'd0, bus8.disp_cnt}, m_transfers % 256);
        check_val("cnt2",     {30'd0, bus2.disp_cnt}, m_transfers % 4);
        if (xfer) begin
            for (int k = 0; k < 4; k++) y[k] = bus8.ch_valid[k] ? bus8.x : 2'd0;
            check_val("demux_y",    {30'd0, y[m_sel]}, m_x);
            check_val("demux_excl", {28'd0, bus8.ch_valid & ~(4'd1 << m_sel)}, 32'd0);
        end
        if (!rn) begin
            m_held = 0; m_x = 0; m_sel = 0; m_ptr = 0; m_transfers = 0;
        end else begin
            if (xfer) begin
                m_transfers++;
                m_ptr = (m_sel + 1) % 4;
            end
            if (acc) begin
                m_x    = d;
                m_held = 1;
                pick   = c_SKIP ? first_ready(m_ptr, rdy) : -1;
                m_sel  = (pick >= 0) ? pick : m_ptr;
            end else if (xfer) begin
                m_held = 0;
            end else if (m_held && c_SKIP) begin
                pick = first_ready((m_sel + 1) % 4, rdy);
                if (pick >= 0) m_sel = pick;
            end
        end
    endtask

    initial begin
        logic [3:0] rdy;
        rst_n         = 1'b0;
        bus8.in_valid = 1'b0;
        bus8.in_data  = 2'd0;
        bus8.ch_ready = 4'd0;
        m_held = 0; m_x = 0; m_sel = 0; m_ptr = 0; m_transfers = 0;

        // Reset, then a full-ready stream of 0,1,2,3,0.
        cycle(0, 0, 0, 4'hf);
        cycle(0, 1, 3, 4'hf);
        for (int i = 0; i < 5; i++) cycle(1, 1, 2'(i % 4), 4'hf);
        cycle(1, 0, 0, 4'hf);
        cycle(1, 0, 0, 4'hf);

        // Stall on channel 0 then release.
        cycle(0, 0, 0, 4'h0);
        cycle(1, 1, 2, 4'h0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 4'h0);
        cycle(1, 0, 0, 4'h1);
        cycle(1, 0, 0, 4'h0);

        // Channel 1 not ready after one transfer.
        cycle(0, 0, 0, 4'hf);
        cycle(1, 1, 1, 4'hf);
        cycle(1, 1, 2, 4'hd);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 4'hd);
        cycle(1, 0, 0, 4'hf);

        // Reset while holding X=3.
        cycle(1, 1, 3, 4'h0);
        cycle(1, 0, 0, 4'h0);
        cycle(0, 0, 0, 4'h0);
        cycle(1, 1, 1, 4'h0);
        cycle(1, 0, 0, 4'hf);

        // Randomized traffic: dense readiness (wraps the 8-bit counter), then sparse.
        for (int i = 0; i < 700; i++) begin
            if (i < 450) rdy = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hf;
            else         rdy = 4'($urandom) & 4'($urandom);
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), rdy);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_dispatch_4.md
RR_DISPATCH_4 -- requirements
Module: RR_DISPATCH_4

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-low.
REQ-002 Parameter BITS_NUM, default 2: width of the data word.
REQ-003 Parameter CNT_BITS, default 8: width of the dispatch counter.
REQ-004 CLK  input  1  rising-edge clock.
REQ-005 RST_N  input  1  synchronous active-low reset.
REQ-006 IN_DATA  input  BITS_NUM  upstream data word.
REQ-007 IN_VALID  input  1  upstream word valid.
REQ-008 IN_READY  output  1  block accepts IN_DATA on this edge.
REQ-009 CH_READY  input  4  per-channel consumer ready, bit k = channel k.
REQ-010 X  output  BITS_NUM  held word; drives X of the downstream 1-to-4 demux.
REQ-011 SEL  output  2  target channel; drives SEL of the downstream demux.
REQ-012 CH_VALID  output  4  one-hot valid for the channel equal to SEL; all zero when idle.
REQ-013 DISP_CNT  output  CNT_BITS  count of completed transfers.

Function
REQ-014 The state machine SHALL have two states: IDLE (no word held) and HOLD (word held in X).
REQ-015 Accept condition: IN_READY = (state==IDLE) OR (state==HOLD AND CH_READY[SEL]==1); an accept occurs on an edge where IN_VALID AND IN_READY.
REQ-016 Transfer condition: state==HOLD AND CH_READY[SEL]==1; on that edge DISP_CNT increments by 1, wrapping from 2^CNT_BITS-1 to 0.
REQ-017 The rotating pointer PTR (2 bits) SHALL become (SEL+1) mod 4 on each transfer, so 3 wraps to 0.
REQ-018 On accept, X <= IN_DATA and SEL <= the target channel computed from the post-transfer PTR; next state HOLD.
REQ-019 Transfer without accept: next state IDLE; X and SEL retain their values; CH_VALID goes to 0.
REQ-020 Simultaneous transfer and accept: the state stays HOLD, giving back-to-back throughput of 1 word per cycle.
REQ-021 HOLD without transfer: X SHALL be stable and CH_VALID SHALL remain asserted.
REQ-022 Latency from accept to CH_VALID asserted: 1 cycle.
REQ-023 CH_VALID SHALL be a combinational decode of state and SEL, with no dependence on CH_READY.

Reset
REQ-024 While RST_N==0 at an edge: state IDLE, PTR=0, SEL=0, X=0, DISP_CNT=0.
REQ-025 Reset during HOLD: the held word is discarded and not counted; CH_VALID=0 from the next cycle.
REQ-026 During reset, IN_READY SHALL reflect the IDLE state after the first reset edge.

Configuration
REQ-027 Macro RR_DISPATCH_SKIP_EN.
REQ-028 Without RR_DISPATCH_SKIP_EN: the target is always PTR, and a stalled channel blocks all traffic (strict order 0,1,2,3,0...).
REQ-029 With RR_DISPATCH_SKIP_EN, at accept: the target is the first channel with CH_READY=1, searched circularly from PTR; if none is ready, the target is PTR.
REQ-030 With RR_DISPATCH_SKIP_EN, in HOLD with CH_READY[SEL]==0: SEL moves on the next edge to the first ready channel, searched circularly from SEL+1; if none is ready, SEL is unchanged.

Structure
REQ-031 A shared package RR_DISPATCH_PKG SHALL hold the state encoding constants (IDLE, HOLD), CH_NUM=4 and SEL_BITS=2.
REQ-032 The circular first-ready search SHALL be a combinational sub-module RR_PICK_4 (inputs START[1:0], REQ[3:0]; outputs GNT[1:0], ANY); it is instantiated only under RR_DISPATCH_SKIP_EN.

Verification
REQ-033 Reset then CH_READY=4'b1111, IN_VALID held 1, IN_DATA=0,1,2,3,0 -> SEL=0,1,2,3,0 on consecutive cycles; X matches IN_DATA; DISP_CNT reaches 5; IN_READY stays 1.
REQ-034 Accept IN_DATA=2 with CH_READY=0 -> CH_VALID=4'b0001 and X=2 held for 3 stall cycles with IN_READY=0; set CH_READY[0]=1 -> one transfer, DISP_CNT=1, PTR=1.
REQ-035 Without the macro, CH_READY=4'b1101 after 1 transfer -> the second word stalls on SEL=1 indefinitely. With the macro, same stimulus -> the second word goes to SEL=2 within 1 cycle.
REQ-036 CNT_BITS=2, 5 transfers -> DISP_CNT sequence 1,2,3,0,1.
REQ-037 RST_N=0 asserted during HOLD with X=3 -> next cycle: CH_VALID=0, X=0, SEL=0, DISP_CNT=0; the first word after reset goes to channel 0.
REQ-038 Compare each transfer against a downstream demux model -> the value on Y[SEL] equals X, and all other channels' CH_VALID bits are 0.
